// File: rtl/iir_inverse_biquad.sv
// Direct-form-I biquad with runtime coefficients, one multiplier shared over 5 MAC cycles.
// Latency 6 cycles; in_ready drops while busy or while out_valid waits for out_ready.
module iir_inverse_biquad #(
    parameter int BIT_NO = 32,
    parameter int CK     = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BIT_NO-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BIT_NO-1:0] out_data,
    input  logic              coef_we,
    input  logic [2:0]        coef_addr,
    input  logic [BIT_NO-1:0] coef_wdata,
    input  logic              hist_clr
);
    localparam int AW = 2 * BIT_NO + 3;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MAC0 = 3'd1;
    localparam logic [2:0] S_MAC1 = 3'd2;
    localparam logic [2:0] S_MAC2 = 3'd3;
    localparam logic [2:0] S_MAC3 = 3'd4;
    localparam logic [2:0] S_MAC4 = 3'd5;
    localparam logic [2:0] S_OUT  = 3'd6;

    localparam logic signed [BIT_NO-1:0] UNITY = BIT_NO'(1 << (CK - 1));
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-BIT_NO+1){1'b0}}, {(BIT_NO-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-BIT_NO+1){1'b1}}, {(BIT_NO-1){1'b0}}};

    logic [2:0] state;

    logic signed [BIT_NO-1:0] sb0, sb1, sb2, sa1, sa2;
    logic signed [BIT_NO-1:0] ab0, ab1, ab2, aa1, aa2;
    logic signed [BIT_NO-1:0] x_cur, x1, x2, y1, y2;
    logic signed [AW-1:0]     acc;

    logic signed [BIT_NO-1:0]   mul_a, mul_b;
    logic signed [2*BIT_NO-1:0] prod;
    logic signed [AW-1:0]       prod_ext;
    logic signed [AW-1:0]       acc_next;
    logic signed [AW-1:0]       acc_shift;
    logic signed [BIT_NO-1:0]   y_sat;
    logic                       accept;

    assign in_ready = (state == S_IDLE) && !out_valid;
    assign accept   = in_valid && in_ready;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            S_MAC0: begin mul_a = ab0; mul_b = x_cur; end
            S_MAC1: begin mul_a = ab1; mul_b = x1;    end
            S_MAC2: begin mul_a = ab2; mul_b = x2;    end
            S_MAC3: begin mul_a = aa1; mul_b = y1;    end
            S_MAC4: begin mul_a = aa2; mul_b = y2;    end
            default: begin mul_a = '0; mul_b = '0;    end
        endcase
    end

    assign prod     = mul_a * mul_b;
    assign prod_ext = {{(AW-2*BIT_NO){prod[2*BIT_NO-1]}}, prod};
    // Feedback terms enter the sum negated.
    assign acc_next = ((state == S_MAC3) || (state == S_MAC4)) ? (acc - prod_ext) : (acc + prod_ext);

    assign acc_shift = acc >>> (CK - 1);

    always_comb begin
        if (acc_shift > SAT_MAX) begin
            y_sat = SAT_MAX[BIT_NO-1:0];
        end else if (acc_shift < SAT_MIN) begin
            y_sat = SAT_MIN[BIT_NO-1:0];
        end else begin
            y_sat = acc_shift[BIT_NO-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb0 <= UNITY;
            sb1 <= '0;
            sb2 <= '0;
            sa1 <= '0;
            sa2 <= '0;
        end else if (coef_we) begin
            case (coef_addr)
                3'd0:    sb0 <= coef_wdata;
                3'd1:    sb1 <= coef_wdata;
                3'd2:    sb2 <= coef_wdata;
                3'd3:    sa1 <= coef_wdata;
                3'd4:    sa2 <= coef_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            acc       <= '0;
            x_cur     <= '0;
            x1        <= '0;
            x2        <= '0;
            y1        <= '0;
            y2        <= '0;
            ab0       <= UNITY;
            ab1       <= '0;
            ab2       <= '0;
            aa1       <= '0;
            aa2       <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (hist_clr) begin
                        x1 <= '0;
                        x2 <= '0;
                        y1 <= '0;
                        y2 <= '0;
                    end
                    // Shadow is sampled before any same-edge write lands.
                    if (accept) begin
                        x_cur <= in_data;
                        ab0   <= sb0;
                        ab1   <= sb1;
                        ab2   <= sb2;
                        aa1   <= sa1;
                        aa2   <= sa2;
                        acc   <= '0;
                        state <= S_MAC0;
                    end
                end
                S_MAC0, S_MAC1, S_MAC2, S_MAC3: begin
                    acc   <= acc_next;
                    state <= state + 3'd1;
                end
                S_MAC4: begin
                    acc   <= acc_next;
                    state <= S_OUT;
                end
                S_OUT: begin
                    out_data  <= y_sat;
                    out_valid <= 1'b1;
                    x2        <= x1;
                    x1        <= x_cur;
                    y2        <= y1;
                    y1        <= y_sat;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iir_inverse_biquad.sv
// Directed bench for iir_inverse_biquad: an equation-level model fills a scoreboard queue
// at each accepted sample; outputs are popped and compared when out_valid rises.
module tb_iir_inverse_biquad;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        coef_we;
    logic [2:0]  coef_addr;
    logic [31:0] coef_wdata;
    logic        hist_clr;

    iir_inverse_biquad #(.BIT_NO(32), .CK(11)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .hist_clr   (hist_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int t0       = 0;

    logic signed [31:0] exp_q[$];
    logic signed [31:0] m_sh[5];
    logic signed [31:0] m_ac[5];
    logic signed [31:0] m_x1, m_x2, m_y1, m_y2;
    logic signed [31:0] held;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sh = '{32'sd1024, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
        m_ac = m_sh;
        m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0;
    endtask

    task automatic model_hist_clr();
        m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0;
    endtask

    task automatic model_accept(input logic signed [31:0] x);
        logic signed [66:0] acc;
        logic signed [31:0] y;
        m_ac = m_sh;
        acc = 67'(m_ac[0]) * 67'(x) + 67'(m_ac[1]) * 67'(m_x1) + 67'(m_ac[2]) * 67'(m_x2)
            - 67'(m_ac[3]) * 67'(m_y1) - 67'(m_ac[4]) * 67'(m_y2);
        acc = acc >>> 10;
        if (acc > 67'sd2147483647)       y = 32'sh7FFFFFFF;
        else if (acc < -67'sd2147483648) y = 32'sh80000000;
        else                             y = acc[31:0];
        exp_q.push_back(y);
        m_x2 = m_x1; m_x1 = x; m_y2 = m_y1; m_y1 = y;
    endtask

    // All tasks start and end on a falling edge.
    task automatic wcoef(input logic [2:0] addr, input logic signed [31:0] val);
        coef_we = 1'b1; coef_addr = addr; coef_wdata = val;
        @(posedge clk);
        if (addr < 3'd5) m_sh[addr] = val;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic hclr();
        hist_clr = 1'b1;
        @(posedge clk);
        model_hist_clr();
        @(negedge clk);
        hist_clr = 1'b0;
    endtask

    task automatic send(input logic signed [31:0] x);
        int n;
        in_valid = 1'b1; in_data = x; n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        model_accept(x);
        @(negedge clk);
        in_valid = 1'b0;
        t0 = cyc;
    endtask

    task automatic recv(input string tag);
        int n;
        logic signed [31:0] e;
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_latency"}, 64'(cyc - t0), 64'd6);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_data"}, $signed(out_data), e);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; hist_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", $signed(out_data), 64'sd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Pass-through defaults
        send(32'sd1000);  recv("t1_a");
        send(-32'sd7);    recv("t1_b");

        // Two-tap average
        hclr();
        wcoef(3'd0, 32'sd512); wcoef(3'd1, 32'sd512);
        send(32'sd100); recv("t2_a");
        send(32'sd300); recv("t2_b");

        // One-pole decay
        hclr();
        wcoef(3'd0, 32'sd1024); wcoef(3'd1, 32'sd0); wcoef(3'd3, -32'sd512);
        wcoef(3'd6, 32'sd77);
        send(32'sd1024);
        recv("t3_0");
        for (int i = 1; i < 5; i++) begin
            send(32'sd0); recv($sformatf("t3_%0d", i));
        end

        // Saturation at both rails
        hclr();
        wcoef(3'd3, 32'sd0); wcoef(3'd0, 32'sd2048);
        send(32'sh7FFFFFFF); recv("t4_pos");
        check("t4_pos_abs", $signed(out_data), 64'sh7FFFFFFF);
        send(32'sh80000000); recv("t4_neg");
        check("t4_neg_abs", $signed(out_data), -64'sd2147483648);

        // Backpressure stall
        hclr();
        wcoef(3'd0, 32'sd1024);
        out_ready = 1'b0;
        send(32'sd123); recv("t5_stall");
        held = 32'sd123;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_hold_valid", 64'(out_valid), 64'd1);
            check("t5_hold_data", $signed(out_data), held);
            check("t5_hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        send(32'sd321); recv("t5_after_stall");

        // Coefficient write mid-sample
        send(32'sd500);
        repeat (2) @(negedge clk);
        wcoef(3'd0, 32'sd0);
        recv("t5_mid_write");
        send(32'sd700); recv("t5_next_zero");
        check("t5_next_zero_abs", $signed(out_data), 64'sd0);

        // Reset while busy
        wcoef(3'd0, 32'sd1024);
        send(32'sd900);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("t6_rst_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        exp_q.delete();
        @(negedge clk);
        check("t6_rst_in_ready", 64'(in_ready), 64'd1);
        wcoef(3'd3, -32'sd512);
        send(32'sd1024); recv("t6_a");
        check("t6_a_abs", $signed(out_data), 64'sd1024);
        send(32'sd0);    recv("t6_b");
        check("t6_b_abs", $signed(out_data), 64'sd512);

        // hist_clr while busy is ignored
        send(32'sd0);
        hist_clr = 1'b1;
        @(negedge clk);
        hist_clr = 1'b0;
        recv("t6_busy_clr");

        // hist_clr in IDLE restarts the recursion
        hclr();
        send(32'sd1024); recv("t6_c");
        send(32'sd0);    recv("t6_d");
        check("t6_d_abs", $signed(out_data), 64'sd512);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
